// File: rtl/actuator_pkg.sv
// rtl/actuator_pkg.sv - state encoding and counter sizing for the hysteresis actuator controller
package actuator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } state_t;

  // One counter serves both dwell and dead-time, so size it for the longer of the two.
  function automatic int cnt_width(input int min_dwell, input int dead_time);
    int longest;
    longest = (min_dwell > dead_time) ? min_dwell : dead_time;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/actuator_ctrl_hyst_dwell_timer.sv
// rtl/actuator_ctrl_hyst_dwell_timer.sv - loadable down-counter that holds at zero
module dwell_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/actuator_ctrl_hyst.sv
// rtl/actuator_ctrl_hyst.sv - heater/fan hysteresis controller with dwell and dead-time interlock
// Optional over-temperature trip: ACT_FAULT_EN
module actuator_ctrl_hyst #(
  parameter int                TEMP_W     = 8,
  parameter int                HYST       = 2,
  parameter int                MIN_DWELL  = 1000,
  parameter int                DEAD_TIME  = 100,
  parameter logic [TEMP_W-1:0] TRIP_LIMIT = TEMP_W'(90)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] setpoint,
  output logic              heater,
  output logic              fan,
  output logic [1:0]        state_o,
  output logic              fault,
  input  logic              fault_clr
);
  import actuator_pkg::*;

  localparam int            CW        = cnt_width(MIN_DWELL, DEAD_TIME);
  localparam logic [CW-1:0] DWELL_CNT = CW'(MIN_DWELL - 1);
  localparam logic [CW-1:0] DEAD_CNT  = CW'(DEAD_TIME - 1);
  localparam logic [TEMP_W:0] HYST_X  = (TEMP_W + 1)'(HYST);

  state_t          state, next_state;
  logic            load;
  logic [CW-1:0]   load_value;
  logic [CW-1:0]   cnt_value;
  logic            cnt_zero;
  logic [TEMP_W:0] temp_x, sp_x;
  logic            heat_on, heat_off, cool_on, cool_off;

  // One extra bit so temp+HYST and setpoint+HYST cannot wrap.
  assign temp_x   = {1'b0, temp};
  assign sp_x     = {1'b0, setpoint};
  assign heat_on  = (temp_x + HYST_X) < sp_x;
  assign heat_off = temp_x >= sp_x;
  assign cool_on  = temp_x > (sp_x + HYST_X);
  assign cool_off = temp_x <= sp_x;

`ifdef ACT_FAULT_EN
  logic fault_q, fault_next;
  logic trip, clr_ok;
  assign trip   = temp_valid && (temp >= TRIP_LIMIT);
  assign clr_ok = fault_q && fault_clr && (temp < TRIP_LIMIT);
`endif

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = DWELL_CNT;
`ifdef ACT_FAULT_EN
    fault_next = fault_q;
`endif
    if (!en) begin
      next_state = DEAD;
    end else begin
      case (state)
        IDLE: if (temp_valid) begin
          if (heat_on)      next_state = HEAT;
          else if (cool_on) next_state = COOL;
        end
        HEAT: if (cnt_zero && temp_valid && heat_off) next_state = DEAD;
        COOL: if (cnt_zero && temp_valid && cool_off) next_state = DEAD;
        DEAD: if (cnt_zero) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
`ifdef ACT_FAULT_EN
    // A trip overrides enable, dwell and dead-time; clearing drops into dead-time.
    if (clr_ok) begin
      fault_next = 1'b0;
      next_state = DEAD;
    end else if (trip || fault_q) begin
      fault_next = 1'b1;
      next_state = COOL;
    end
`endif
    if (next_state != state) begin
      if (next_state == HEAT || next_state == COOL) begin
        load       = 1'b1;
        load_value = DWELL_CNT;
      end else if (next_state == DEAD) begin
        load       = 1'b1;
        load_value = DEAD_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      heater <= 1'b0;
      fan    <= 1'b0;
    end else begin
      state  <= next_state;
      heater <= (next_state == HEAT);
      fan    <= (next_state == COOL);
    end
  end

`ifdef ACT_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_next;
  end
  assign fault = fault_q;
`else
  logic unused_fault;
  assign unused_fault = &{1'b0, fault_clr, TRIP_LIMIT};
  assign fault        = 1'b0;
`endif

  assign state_o = state;

  dwell_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (load_value),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

endmodule

// File: doc/actuator_ctrl_hyst.md
Name: actuator_ctrl_hyst

Overview:
Registered heater/fan controller with a hysteresis band and a minimum dwell time per actuator. It adds a dead-time interlock so the heater and fan are never driven together or switched back-to-back. It is the parametrised successor of the combinational compare-and-drive stage. It sits between the temperature sample path (temp/temp_valid) and the actuator pins.

Parameters:
TEMP_W, 8, width of temp and setpoint (unsigned)
HYST, 2, half-width of the deadband in temperature LSBs; 0 ≤ HYST < 2^TEMP_W
MIN_DWELL, 1000, minimum cycles an actuator stays on once switched on; ≥ 1
DEAD_TIME, 100, cycles both actuators are held off after either turns off; ≥ 1
TRIP_LIMIT, 8'd90, over-temperature trip threshold (used only with ACT_FAULT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  control enable; low forces both actuators off
temp_valid  in  1  one-cycle strobe, temp is valid
temp  in  TEMP_W  measured temperature, unsigned
setpoint  in  TEMP_W  target temperature, unsigned, sampled every cycle
heater  out  1  heater drive, registered
fan  out  1  fan drive, registered
state_o  out  2  current FSM state (encoding from package)
fault  out  1  latched over-temperature fault (0 without ACT_FAULT_EN)
fault_clr  in  1  clears fault (ignored without ACT_FAULT_EN)

Behaviour:
- Reset (rst_n low, async): state=IDLE, heater=0, fan=0, fault=0, dwell counter=0.
- Compares use TEMP_W+1-bit arithmetic; no wrap.
  - heat_on: temp + HYST < setpoint
  - heat_off: temp ≥ setpoint
  - cool_on: temp > setpoint + HYST
  - cool_off: temp ≤ setpoint
- Decisions are made only on cycles where temp_valid=1. Temperature comparisons are ignored otherwise; timers still count.
- States: IDLE, HEAT, COOL, DEAD.
  - IDLE: on temp_valid && en: heat_on → HEAT; else cool_on → COOL. heat_on and cool_on are mutually exclusive by construction.
  - HEAT: load dwell counter with MIN_DWELL-1 on entry. Exit to DEAD when counter==0 && temp_valid && heat_off.
  - COOL: same rule with cool_off.
  - DEAD: load counter with DEAD_TIME-1 on entry; → IDLE when counter==0. Never goes directly from DEAD to HEAT/COOL.
- Outputs are registered from the next state: heater=(next==HEAT), fan=(next==COOL).
  - Latency: temp_valid sampled at edge N gives heater/fan changed after edge N.
  - heater && fan is never 1 in the same cycle.
- en low in any state: next state DEAD, even from HEAT/COOL with dwell remaining. Both outputs 0 after the next edge. DEAD counts normally but stays in DEAD while en=0.
- Setpoint change mid-dwell: no effect until dwell expires.
- Reset mid-operation: immediate return to reset values. No dwell or dead-time is remembered.
- Counter width: $clog2(max(MIN_DWELL,DEAD_TIME)+1).

Optional Feature:
ACT_FAULT_EN
- Defined:
  - temp_valid && temp ≥ TRIP_LIMIT sets fault (sticky) and forces state COOL, bypassing dwell and dead-time. The heater drops the same edge.
  - While fault=1: fan=1, heater=0, HEAT is unreachable.
  - fault_clr clears fault only when temp < TRIP_LIMIT on that cycle. Otherwise the clear is ignored. State then → DEAD.
- Undefined: fault tied 0, fault_clr unused, TRIP_LIMIT unused.

Decomposition:
- Package actuator_pkg holds:
  - the state encoding: IDLE=2'd0, HEAT=2'd1, COOL=2'd2, DEAD=2'd3
  - a function for the counter width
- Sub-module dwell_timer: loadable down-counter with load, value, and zero flag; one instance is shared by HEAT/COOL dwell and DEAD.

Test Plan:
- Reset release with setpoint=50, temp=47, valid pulse, HYST=2 → heater=1 one edge later, state=HEAT, fan=0.
- temp=49 (inside the deadband) from IDLE → no change. temp=53 → fan=1 after one edge.
- In HEAT, temp=60 applied at cycle 10 of MIN_DWELL=20 → heater stays 1 until the counter expires. Then DEAD for exactly 5 cycles (DEAD_TIME=5), then IDLE.
- HEAT→COOL demand: temp jumps 40→70 after the dwell → the sequence shows HEAT, DEAD(DEAD_TIME cycles), IDLE, COOL. heater&&fan is never asserted (assertion over the whole run).
- en dropped mid-HEAT → heater=0 next edge. State stays DEAD while en=0 and resumes control after en=1 and dead-time.
- ACT_FAULT_EN, TRIP_LIMIT=90:
  - temp=95 in HEAT → fault=1, fan=1, heater=0 next edge.
  - fault_clr with temp=95 is ignored.
  - fault_clr with temp=80 → fault=0 and state=DEAD.
